// File: rtl/mem_port_arbiter.sv
// Shares one Wishbone-style memory port between the IF and MEM pipeline requesters.
// Optional ack watchdog compiled in with `define MEM_ARB_TIMEOUT_EN (adds bus_timeout port).
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_stallreq,
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W/8-1:0] mem_sel,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_stallreq,
   output logic                bus_cyc,
   output logic                bus_stb,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_sel,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_ack
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   output logic                bus_timeout
`endif
);

   typedef enum logic [1:0] {IDLE, GNT_MEM, GNT_IF, DRAIN} state_t;

   if (TIMEOUT < 2) begin : g_timeout_range
      $error("mem_port_arbiter: TIMEOUT must be at least 2");
   end

   state_t              state_reg;
   logic                stb_reg;
   logic                we_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [DATA_W/8-1:0] sel_reg;
   logic                done;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_reg;
   logic             timeout;

   // Counter restarts in IDLE, so it is zero in the first strobe cycle of every access.
   always_ff @(posedge clk) begin
      if (!rst_n || state_reg == IDLE)
         cnt_reg <= '0;
      else if (cnt_reg != CNT_W'(TIMEOUT))
         cnt_reg <= cnt_reg + 1'b1;
   end

   assign timeout     = (state_reg != IDLE) && !bus_ack && (cnt_reg == CNT_W'(TIMEOUT));
   assign done        = bus_ack | timeout;
   assign bus_timeout = timeout;
`else
   assign done = bus_ack;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         stb_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         sel_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!flush && mem_req) begin
                  state_reg <= GNT_MEM;
                  stb_reg   <= 1'b1;
                  we_reg    <= mem_we;
                  addr_reg  <= mem_addr;
                  wdata_reg <= mem_wdata;
                  sel_reg   <= mem_sel;
               end else if (!flush && if_req) begin
                  state_reg <= GNT_IF;
                  stb_reg   <= 1'b1;
                  we_reg    <= 1'b0;
                  addr_reg  <= if_addr;
                  wdata_reg <= '0;
                  sel_reg   <= '1;
               end
            end
            GNT_MEM, GNT_IF: begin
               // An ack in the flush cycle still completes normally.
               if (done) begin
                  state_reg <= IDLE;
                  stb_reg   <= 1'b0;
               end else if (flush) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (done) begin
                  state_reg <= IDLE;
                  stb_reg   <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               stb_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign bus_cyc   = stb_reg;
   assign bus_stb   = stb_reg;
   assign bus_we    = we_reg;
   assign bus_addr  = addr_reg;
   assign bus_wdata = wdata_reg;
   assign bus_sel   = sel_reg;

   assign mem_stallreq = !flush && mem_req && !(state_reg == GNT_MEM && done);
   assign if_stallreq  = !flush && if_req  && !(state_reg == GNT_IF  && done);

   // Data is only forwarded on a real ack; drained and timed-out accesses read as zero.
   assign mem_rdata = (state_reg == GNT_MEM && bus_ack) ? bus_rdata : '0;
   assign if_rdata  = (state_reg == GNT_IF  && bus_ack) ? bus_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus queues expected bus
// transfers and read data; a negedge monitor pops and compares on each completion.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_stallreq;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_sel;
   logic [31:0] mem_rdata;
   logic        mem_stallreq;
   logic        bus_cyc;
   logic        bus_stb;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_sel;
   logic [31:0] bus_rdata;
   logic        bus_ack;
`ifdef MEM_ARB_TIMEOUT_EN
   logic        bus_timeout;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stallreq(if_stallreq),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_stallreq(mem_stallreq),
      .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
`ifdef MEM_ARB_TIMEOUT_EN
      , .bus_timeout(bus_timeout)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      bit          chk_wdata;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   logic [31:0] if_q[$];
   logic [31:0] mem_q[$];
   int checks   = 0;
   int failures = 0;
   int stall_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input bit cw);
      bus_exp_t e;
      e.we = we; e.addr = addr; e.wdata = wdata; e.sel = sel; e.chk_wdata = cw;
      bus_q.push_back(e);
   endtask

   // Monitor: every completed bus transfer and every released requester is checked.
   always @(negedge clk) begin
      if (bus_stb && bus_ack) begin
         bus_exp_t e;
         chk("bus_cyc_eq_stb", {31'd0, bus_cyc}, {31'd0, bus_stb});
         if (bus_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL bus_unexpected actual addr=%h expected=no transfer", bus_addr);
         end else begin
            e = bus_q.pop_front();
            $display("bus txn we=%0d addr=%h wdata=%h sel=%h rdata=%h",
                     bus_we, bus_addr, bus_wdata, bus_sel, bus_rdata);
            chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_sel", {28'd0, bus_sel}, {28'd0, e.sel});
            if (e.chk_wdata) chk("bus_wdata", bus_wdata, e.wdata);
         end
      end
      if (if_req && !if_stallreq && !flush) begin
         if (if_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL if_unexpected actual rdata=%h expected=no completion", if_rdata);
         end else begin
            chk("if_rdata", if_rdata, if_q.pop_front());
         end
      end
      if (mem_req && !mem_stallreq && !flush) begin
         if (mem_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mem_unexpected actual rdata=%h expected=no completion", mem_rdata);
         end else begin
            chk("mem_rdata", mem_rdata, mem_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_sel = '0;
      bus_rdata = '0; bus_ack = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("reset_stb", {31'd0, bus_stb}, 32'd0);
      chk("reset_sel", {28'd0, bus_sel}, 32'd0);

      // Stray ack in IDLE must be ignored.
      tick(); rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h77777777;
      @(negedge clk);
      chk("idle_ack_stb", {31'd0, bus_stb}, 32'd0);
      chk("idle_ack_if_rdata", if_rdata, 32'd0);
      chk("idle_ack_mem_rdata", mem_rdata, 32'd0);
      tick(); bus_ack = 1'b0; bus_rdata = '0;
      @(negedge clk);
      chk("idle_still_idle", {31'd0, bus_stb}, 32'd0);

      // IF read, acked in first strobe cycle.
      tick(); if_req = 1'b1; if_addr = 32'h100;
      push_bus(1'b0, 32'h100, 32'h0, 4'hF, 1'b0); if_q.push_back(32'h3C011234);
      @(negedge clk);
      chk("t1_stall_req_cycle", {31'd0, if_stallreq}, 32'd1);
      chk("t1_stb_req_cycle", {31'd0, bus_stb}, 32'd0);
      tick(); bus_ack = 1'b1; bus_rdata = 32'h3C011234;
      @(negedge clk);
      chk("t1_stb_ack_cycle", {31'd0, bus_stb}, 32'd1);
      chk("t1_stall_ack_cycle", {31'd0, if_stallreq}, 32'd0);
      tick(); if_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      @(negedge clk);
      chk("t1_stb_after", {31'd0, bus_stb}, 32'd0);

      // Simultaneous requests: MEM write first, one IDLE cycle, then IF.
      tick(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
      mem_sel = 4'hF; if_req = 1'b1; if_addr = 32'h104;
      push_bus(1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b1); mem_q.push_back(32'h55AA55AA);
      @(negedge clk);
      chk("t2_mem_stall", {31'd0, mem_stallreq}, 32'd1);
      chk("t2_if_stall", {31'd0, if_stallreq}, 32'd1);
      tick(); bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
      @(negedge clk);
      chk("t2_mem_we", {31'd0, bus_we}, 32'd1);
      chk("t2_mem_stall_ack", {31'd0, mem_stallreq}, 32'd0);
      chk("t2_if_stall_during_mem", {31'd0, if_stallreq}, 32'd1);
      tick(); mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      @(negedge clk);
      chk("t2_idle_gap_stb", {31'd0, bus_stb}, 32'd0);
      chk("t2_if_stall_gap", {31'd0, if_stallreq}, 32'd1);
      push_bus(1'b0, 32'h104, 32'h0, 4'hF, 1'b0); if_q.push_back(32'h24020001);
      tick(); bus_ack = 1'b1; bus_rdata = 32'h24020001;
      @(negedge clk);
      chk("t2_if_stb", {31'd0, bus_stb}, 32'd1);
      chk("t2_if_we", {31'd0, bus_we}, 32'd0);
      tick(); if_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;

      // MEM read with 3 wait cycles; garbage on rdata until ack.
      tick(); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000; mem_wdata = '0;
      mem_sel = 4'b0011; bus_rdata = 32'hBAD0BAD0;
      push_bus(1'b0, 32'h3000, 32'h0, 4'b0011, 1'b1); mem_q.push_back(32'hCAFEF00D);
      stall_cnt = 0;
      @(negedge clk);
      if (mem_stallreq) stall_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("t3_wait_stb", {31'd0, bus_stb}, 32'd1);
         chk("t3_wait_addr", bus_addr, 32'h3000);
         chk("t3_wait_rdata", mem_rdata, 32'd0);
         if (mem_stallreq) stall_cnt++;
      end
      tick(); bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      if (mem_stallreq) stall_cnt++;
      chk("t3_stall_cycles", stall_cnt, 32'd4);
      tick(); mem_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      @(negedge clk);
      chk("t3_stb_after", {31'd0, bus_stb}, 32'd0);

      // Flush during pending IF read: drain, discard, then refetch from 0x40.
      tick(); if_req = 1'b1; if_addr = 32'h200;
      push_bus(1'b0, 32'h200, 32'h0, 4'hF, 1'b0);
      @(negedge clk);
      chk("t4_stall_req", {31'd0, if_stallreq}, 32'd1);
      tick();
      @(negedge clk);
      chk("t4_stb_pending", {31'd0, bus_stb}, 32'd1);
      tick(); flush = 1'b1; bus_rdata = 32'h99999999;
      @(negedge clk);
      chk("t4_stall_flush", {31'd0, if_stallreq}, 32'd0);
      chk("t4_rdata_flush", if_rdata, 32'd0);
      tick(); flush = 1'b0; if_addr = 32'h40;
      @(negedge clk);
      chk("t4_drain_stb", {31'd0, bus_stb}, 32'd1);
      chk("t4_drain_addr", bus_addr, 32'h200);
      chk("t4_drain_stall", {31'd0, if_stallreq}, 32'd1);
      tick(); bus_ack = 1'b1;
      @(negedge clk);
      chk("t4_drain_ack_rdata", if_rdata, 32'd0);
      chk("t4_drain_ack_stall", {31'd0, if_stallreq}, 32'd1);
      tick(); bus_ack = 1'b0; bus_rdata = '0;
      @(negedge clk);
      chk("t4_idle_stb", {31'd0, bus_stb}, 32'd0);
      chk("t4_idle_stall", {31'd0, if_stallreq}, 32'd1);
      push_bus(1'b0, 32'h40, 32'h0, 4'hF, 1'b0); if_q.push_back(32'h08000000);
      tick(); bus_ack = 1'b1; bus_rdata = 32'h08000000;
      @(negedge clk);
      chk("t4_new_addr", bus_addr, 32'h40);
      chk("t4_new_stall", {31'd0, if_stallreq}, 32'd0);
      tick(); if_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;

      // Reset while a MEM write is on the bus.
      tick(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h4000; mem_wdata = 32'h12345678;
      mem_sel = 4'hC;
      @(negedge clk);
      chk("t5_req_stb", {31'd0, bus_stb}, 32'd0);
      tick();
      @(negedge clk);
      chk("t5_active_stb", {31'd0, bus_stb}, 32'd1);
      chk("t5_active_wdata", bus_wdata, 32'h12345678);
      tick(); rst_n = 1'b0;
      @(negedge clk);
      chk("t5_pre_reset_stb", {31'd0, bus_stb}, 32'd1);
      tick(); rst_n = 1'b1;
      @(negedge clk);
      chk("t5_rst_cyc", {31'd0, bus_cyc}, 32'd0);
      chk("t5_rst_stb", {31'd0, bus_stb}, 32'd0);
      chk("t5_rst_we", {31'd0, bus_we}, 32'd0);
      chk("t5_rst_addr", bus_addr, 32'd0);
      chk("t5_rst_wdata", bus_wdata, 32'd0);
      chk("t5_rst_sel", {28'd0, bus_sel}, 32'd0);
      chk("t5_rst_mem_stall", {31'd0, mem_stallreq}, 32'd1);
      chk("t5_rst_if_stall", {31'd0, if_stallreq}, 32'd0);
      push_bus(1'b1, 32'h4000, 32'h12345678, 4'hC, 1'b1); mem_q.push_back(32'h0);
      tick(); bus_ack = 1'b1; bus_rdata = '0;
      @(negedge clk);
      chk("t5_retry_stall", {31'd0, mem_stallreq}, 32'd0);
      tick(); mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
      @(negedge clk);
      chk("end_bus_q_empty", bus_q.size(), 32'd0);
      chk("end_if_q_empty", if_q.size(), 32'd0);
      chk("end_mem_q_empty", mem_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
